logic_op_arbiter: RTL and testbench
===================================

// Module: logic_op_arbiter
// PURPOSE
//  Shares one bitwise logic unit (AND/OR/XOR/NOR/NOT) between NUM_REQ requesters.
//  Round-robin arbitration; valid/ready handshake per requester; one-entry registered result.
//  Sits between issue ports (e.g. ALU front end, address-gen) and the ALU logic datapath.
// PARAMETERS
//  DATA_WIDTH  32  operand/result width
//  NUM_REQ     4   number of requesters (>=2)
//  ID_W        2   requester index width, = clog2(NUM_REQ); derived, do not override
// PORTS
//  clk         in   1                   rising-edge clock
//  rst_n       in   1                   async active-low reset
//  req_valid   in   NUM_REQ             per-requester request valid
//  req_ready   out  NUM_REQ             per-requester accept (one-hot or zero)
//  req_op      in   3*NUM_REQ           opcode, requester i at [3i+2:3i]
//  req_a       in   DATA_WIDTH*NUM_REQ  operand A, requester i at [DW*i +: DW]
//  req_b       in   DATA_WIDTH*NUM_REQ  operand B (ignored for NOT)
//  rsp_valid   out  1                   result register holds a result
//  rsp_ready   in   1                   consumer accepts result
//  rsp_data    out  DATA_WIDTH          result
//  rsp_id      out  ID_W                index of requester that issued result
//  rsp_err     out  1                   illegal opcode flag for this result
// BEHAVIOUR
//  Clocking/reset: one clock; reset is asynchronous and active-low.
//  rst_n low: rsp_valid=0, rsp_data=0, rsp_id=0, rsp_err=0, rr pointer=0, state EMPTY.
//  req_ready=0 while in reset; reset mid-transaction drops held result, no replay.
//  Opcodes: 000 A&B, 001 A|B, 010 A^B, 011 ~(A|B), 100 ~A;
//   101-111 illegal -> rsp_data=0, rsp_err=1 (still a normal handshake).
//  Result register states: EMPTY (rsp_valid=0), FULL (rsp_valid=1).
//  can_accept = EMPTY | (FULL & rsp_ready).
//  Arbitration (combinational, same cycle): scan requesters starting at pointer ptr,
//   wrapping NUM_REQ-1 -> 0; first with req_valid=1 is winner g.
//  req_ready[g]=can_accept; all other req_ready=0; no valid -> req_ready all 0.
//  req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
//  Transfer on req_valid[g]&req_ready[g] at edge N: result/id/err registered,
//   rsp_valid=1 from cycle N+1 (latency 1), ptr <= (g+1) mod NUM_REQ.
//  No transfer: ptr unchanged.
//  Transitions: EMPTY+transfer->FULL; FULL+rsp_ready+transfer->FULL (new data);
//   FULL+rsp_ready+no transfer->EMPTY; FULL+!rsp_ready->FULL, outputs held bit-stable.
//  Throughput: 1 result/cycle with rsp_ready held high.
//  Requesters hold req_valid/op/operands stable until accepted; unaccepted requests
//   retain priority order (starvation-free: waiting requester served within NUM_REQ grants).
//  Widths: pure bitwise, no carry/extension; rsp_id is the binary index of g.
// TESTING
//  1 Reset: assert rst_n=0 mid-FULL -> rsp_valid, rsp_data, rsp_id, req_ready all 0 same cycle, ptr=0.
//  2 Single req: req1 op=000 A=F0F0_1234 B=0FF0_FFFF, rsp_ready=1
//    -> next cycle rsp_valid=1, rsp_data=00F0_1234, rsp_id=1, rsp_err=0.
//  3 Round-robin: all 4 valid continuously, rsp_ready=1 -> grants 0,1,2,3,0,... one per cycle.
//  4 Backpressure: FULL, rsp_ready=0 for 5 cycles -> req_ready=0, rsp_* stable;
//    rsp_ready=1 -> drain and accept same edge, rsp_valid stays 1.
//  5 Opcodes: A=AAAA_AAAA B=0000_FFFF: 001->AAAA_FFFF, 010->AAAA_5555, 011->5555_0000,
//    100->5555_5555; op=110 -> rsp_data=0, rsp_err=1.
//  6 Wrap/starvation: ptr=3, req0 and req3 valid -> req3 first, req0 next, ptr ends 1.

Source files
------------

// File: rtl/logic_op_arbiter.sv
// rtl/logic_op_arbiter.sv - round-robin shared bitwise logic unit with one-entry result register
module logic_op_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [3*NUM_REQ-1:0]          req_op,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]               rsp_id,
  output logic                          rsp_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state;
  logic [ID_W-1:0]       ptr;
  logic [ID_W-1:0]       grant_idx;
  logic                  grant_found;
  logic                  can_accept;
  logic                  xfer;
  logic [2:0]            sel_op;
  logic [DATA_WIDTH-1:0] sel_a;
  logic [DATA_WIDTH-1:0] sel_b;
  logic [DATA_WIDTH-1:0] calc_data;
  logic                  calc_err;
  logic [ID_W-1:0]       ptr_next;

  // Round-robin scan: first valid requester at or after ptr, wrapping to 0.
  always_comb begin
    int idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

  // The result slot can take a new entry when empty or when it drains this cycle.
  assign can_accept = (state == EMPTY) || rsp_ready;
  assign xfer       = grant_found && can_accept && rst_n;
  assign rsp_valid  = (state == FULL);
  assign ptr_next   = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

  // One-hot ready to the winner only; held low while reset is asserted.
  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[grant_idx] = 1'b1;
  end

  // Operand mux and the shared logic unit; illegal opcodes yield zero with an error flag.
  always_comb begin
    int gi;
    gi        = int'(grant_idx);
    sel_op    = req_op[3*gi +: 3];
    sel_a     = req_a[DATA_WIDTH*gi +: DATA_WIDTH];
    sel_b     = req_b[DATA_WIDTH*gi +: DATA_WIDTH];
    calc_err  = 1'b0;
    calc_data = '0;
    case (sel_op)
      3'b000:  calc_data = sel_a & sel_b;
      3'b001:  calc_data = sel_a | sel_b;
      3'b010:  calc_data = sel_a ^ sel_b;
      3'b011:  calc_data = ~(sel_a | sel_b);
      3'b100:  calc_data = ~sel_a;
      default: calc_err  = 1'b1;
    endcase
  end

  // Result register FSM plus the rotating priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      ptr      <= '0;
      rsp_data <= '0;
      rsp_id   <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (xfer) begin
        state    <= FULL;
        ptr      <= ptr_next;
        rsp_data <= calc_data;
        rsp_id   <= grant_idx;
        rsp_err  <= calc_err;
      end else if (state == FULL && rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// tb/tb_logic_op_arbiter.sv - randomized and directed checks of logic_op_arbiter against a reference model
module tb_logic_op_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [3*N-1:0]  req_op;
  logic [DW*N-1:0] req_a;
  logic [DW*N-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_id;
  logic            rsp_err;

  logic_op_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  bit          m_err;
  int          m_ptr;

  // stimulus vectors under construction
  logic [N-1:0]    t_v;
  logic [3*N-1:0]  t_op;
  logic [DW*N-1:0] t_a;
  logic [DW*N-1:0] t_b;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0:    return {1'b0, a & b};
      3'd1:    return {1'b0, a | b};
      3'd2:    return {1'b0, a ^ b};
      3'd3:    return {1'b0, ~(a | b)};
      3'd4:    return {1'b0, ~a};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic set_slot(input int i, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    t_v[i]         = 1'b1;
    t_op[3*i +: 3] = op;
    t_a[DW*i +: DW] = a;
    t_b[DW*i +: DW] = b;
  endtask

  task automatic clear_slots();
    t_v = '0; t_op = '0; t_a = '0; t_b = '0;
  endtask

  // One cycle: drive at negedge, compare outputs and ready, then advance the model at posedge.
  task automatic step(input logic rr, output int g);
    logic [N-1:0] exp_ready;
    logic [32:0]  r;
    bit           can;
    @(negedge clk);
    req_valid = t_v; req_op = t_op; req_a = t_a; req_b = t_b; rsp_ready = rr;
    #1;
    check("rsp_valid", rsp_valid, m_full);
    if (m_full) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_id", rsp_id, m_id);
      check("rsp_err", rsp_err, m_err);
    end
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && t_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    can = !m_full || rr;
    exp_ready = '0;
    if (g >= 0 && can) exp_ready[g] = 1'b1;
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    if (exp_ready != 0) begin
      r      = ref_op(t_op[3*g +: 3], t_a[DW*g +: DW], t_b[DW*g +: DW]);
      m_err  = r[32];
      m_data = r[31:0];
      m_id   = g;
      m_full = 1;
      m_ptr  = (g + 1) % N;
    end else begin
      if (rr) m_full = 0;
      g = -1;
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    req_valid = '1; rsp_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_data", rsp_data, 32'h0);
    check("rst_id", rsp_id, 2'd0);
    check("rst_err", rsp_err, 1'b0);
    check("rst_ready", req_ready, 4'b0000);
    m_full = 0; m_ptr = 0; m_data = '0; m_id = 0; m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
  endtask

  logic [2:0]  op_list  [6] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110};
  logic [31:0] exp_list [6] = '{32'h0000_AAAA, 32'hAAAA_FFFF, 32'hAAAA_5555,
                                32'h5555_0000, 32'h5555_5555, 32'h0000_0000};

  bit          pv [N];
  logic [2:0]  pop [N];
  logic [31:0] pa [N];
  logic [31:0] pb [N];
  int          waitcnt [N];

  initial begin
    int g;
    logic [31:0] held;
    rst_n = 1'b0;
    req_valid = '1; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    m_full = 0; m_ptr = 0; m_data = '0; m_id = 0; m_err = 0;
    clear_slots();
    repeat (2) @(negedge clk);
    check("in_reset_ready", req_ready, 4'b0000);
    check("in_reset_valid", rsp_valid, 1'b0);
    rst_n = 1'b1;
    req_valid = '0;

    // single request from requester 1
    clear_slots();
    set_slot(1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FFFF);
    step(1'b1, g);
    check("single_grant", g, 1);
    #1;
    check("single_valid", rsp_valid, 1'b1);
    check("single_data", rsp_data, 32'h00F0_1234);
    check("single_id", rsp_id, 2'd1);
    check("single_err", rsp_err, 1'b0);

    // every opcode through requester 0
    foreach (op_list[i]) begin
      clear_slots();
      set_slot(0, op_list[i], 32'hAAAA_AAAA, 32'h0000_FFFF);
      step(1'b1, g);
      #1;
      check("op_data", rsp_data, exp_list[i]);
      check("op_err", rsp_err, (i == 5));
    end

    // reset while holding a result, then round-robin from pointer 0
    clear_slots();
    set_slot(2, 3'b001, 32'h1, 32'h2);
    step(1'b0, g);
    reset_mid();
    clear_slots();
    for (int i = 0; i < N; i++) set_slot(i, 3'(i), 32'h1234_5678 * (i + 1), 32'h0F0F_0F0F);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, g);
      check("rr_grant", g, i % N);
    end

    // backpressure: slot full, consumer stalls for 5 cycles
    #1 held = rsp_data;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, g);
      check("bp_no_grant", g, -1);
      check("bp_hold", rsp_data, held);
    end
    step(1'b1, g);
    check("bp_drain_grant", g, 0);
    #1 check("bp_still_valid", rsp_valid, 1'b1);

    // wrap: move pointer to 3, then req0 and req3 contend
    reset_mid();
    clear_slots();
    set_slot(2, 3'b010, 32'hFFFF_0000, 32'h00FF_00FF);
    step(1'b1, g);
    clear_slots();
    set_slot(0, 3'b100, 32'h0000_0001, 32'h0);
    set_slot(3, 3'b000, 32'hFFFF_FFFF, 32'h8000_0001);
    step(1'b1, g);
    check("wrap_first", g, 3);
    t_v[3] = 1'b0;
    step(1'b1, g);
    check("wrap_second", g, 0);
    clear_slots();
    for (int i = 0; i < N; i++) set_slot(i, 3'b001, 32'h0, 32'h0);
    step(1'b1, g);
    check("wrap_ptr_end", g, 1);

    // randomized traffic with held requests and random consumer stalls
    for (int i = 0; i < N; i++) begin pv[i] = 0; waitcnt[i] = 0; end
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; pop[i] = 3'($urandom_range(0, 7));
          pa[i] = $urandom; pb[i] = $urandom; waitcnt[i] = 0;
        end
      end
      clear_slots();
      for (int i = 0; i < N; i++) if (pv[i]) set_slot(i, pop[i], pa[i], pb[i]);
      step($urandom_range(0, 3) != 0, g);
      if (g >= 0) begin
        check("starve_bound", waitcnt[g] < N, 1'b1);
        pv[g] = 0;
        for (int i = 0; i < N; i++) if (pv[i]) waitcnt[i]++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
